wb_mem_slave: RTL and testbench

Wishbone responder at the far end of the shared buses driven by the CPU arbiter. It serves the data bus (read/write) and the instruction-fetch bus (read-only) from one unified word-addressed memory. Each port has its own handshake state machine with a parameterised wait-state count. The block replaces the per-CPU direct instruction/data RAMs once all cores share one memory.

---
 rtl/wb_mem_slave.sv | 186 ++++++++++++++++++
 tb/tb_wb_mem_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone responder serving a data bus (read/write) and an
// instruction-fetch bus (read-only) from one unified word-addressed memory.
// Each port has its own IDLE/WAIT/ACK handshake FSM with a fixed wait count.
// Optional feature macro: WB_MEM_RANGE_ERR_EN flags accesses with nonzero
// address bits above AW (acked, reads return 0, writes dropped, sticky err_flag).
// Without it, upper address bits are ignored and accesses alias.
module wb_mem_slave #(
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int PCW       = 32,
    parameter int WAIT_DATA = 1,
    parameter int WAIT_INST = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wb_cyc,
    input  logic           wb_stb,
    input  logic           wb_we,
    input  logic [DW-1:0]  wb_adr,
    input  logic [DW-1:0]  wb_dat_i,
    output logic [DW-1:0]  wb_dat_o,
    output logic           wb_ack,
    input  logic           wb_inst_cyc,
    input  logic           wb_inst_stb,
    input  logic [PCW-1:0] wb_inst_pc,
    output logic [DW-1:0]  wb_inst_o,
    output logic           wb_inst_ack,
    output logic           err_flag
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WD = 4'(WAIT_DATA);
    localparam logic [3:0] WI = 4'(WAIT_INST);

    logic [DW-1:0] mem [0:(2**AW)-1];

    state_t        d_state, d_state_n, i_state, i_state_n;
    logic [3:0]    d_cnt, d_cnt_n, i_cnt, i_cnt_n;
    logic          d_enter, i_enter;
    logic [AW-1:0] d_idx, i_idx, d_idx_eff, i_idx_eff;
    logic          d_we, d_we_eff;
    logic [DW-1:0] d_wdat, d_wdat_eff;
    logic          d_oor, i_oor, d_oor_in, i_oor_in, d_oor_eff, i_oor_eff;

`ifdef WB_MEM_RANGE_ERR_EN
    assign d_oor_in = |wb_adr[DW-1:AW];
    assign i_oor_in = |wb_inst_pc[PCW-1:AW];
`else
    logic unused_upper_bits;
    assign d_oor_in = 1'b0;
    assign i_oor_in = 1'b0;
    assign unused_upper_bits = ^{wb_adr[DW-1:AW], wb_inst_pc[PCW-1:AW]};
`endif

    // A zero-wait access enters ACK straight from IDLE, before anything is
    // latched, so the request fields come from the bus in IDLE.
    assign d_idx_eff  = (d_state == S_IDLE) ? wb_adr[AW-1:0]     : d_idx;
    assign d_we_eff   = (d_state == S_IDLE) ? wb_we              : d_we;
    assign d_wdat_eff = (d_state == S_IDLE) ? wb_dat_i           : d_wdat;
    assign d_oor_eff  = (d_state == S_IDLE) ? d_oor_in           : d_oor;
    assign i_idx_eff  = (i_state == S_IDLE) ? wb_inst_pc[AW-1:0] : i_idx;
    assign i_oor_eff  = (i_state == S_IDLE) ? i_oor_in           : i_oor;

    // Data port next state; d_enter marks the edge that moves into ACK.
    always_comb begin
        d_state_n = d_state;
        d_cnt_n   = d_cnt;
        d_enter   = 1'b0;
        case (d_state)
            S_IDLE: if (wb_cyc && wb_stb) begin
                d_cnt_n = WD;
                if (WD == 4'd0) begin
                    d_state_n = S_ACK;
                    d_enter   = 1'b1;
                end else begin
                    d_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                d_cnt_n = d_cnt - 4'd1;
                if (!wb_cyc) begin
                    d_state_n = S_IDLE;
                    d_cnt_n   = 4'd0;
                end else if (d_cnt == 4'd1) begin
                    d_state_n = S_ACK;
                    d_enter   = 1'b1;
                end
            end
            default: d_state_n = S_IDLE;
        endcase
    end

    // Instruction port next state, same handshake without writes.
    always_comb begin
        i_state_n = i_state;
        i_cnt_n   = i_cnt;
        i_enter   = 1'b0;
        case (i_state)
            S_IDLE: if (wb_inst_cyc && wb_inst_stb) begin
                i_cnt_n = WI;
                if (WI == 4'd0) begin
                    i_state_n = S_ACK;
                    i_enter   = 1'b1;
                end else begin
                    i_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                i_cnt_n = i_cnt - 4'd1;
                if (!wb_inst_cyc) begin
                    i_state_n = S_IDLE;
                    i_cnt_n   = 4'd0;
                end else if (i_cnt == 4'd1) begin
                    i_state_n = S_ACK;
                    i_enter   = 1'b1;
                end
            end
            default: i_state_n = S_IDLE;
        endcase
    end

    // State, counters and request latches for both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= S_IDLE;
            i_state <= S_IDLE;
            d_cnt   <= 4'd0;
            i_cnt   <= 4'd0;
            d_idx   <= '0;
            i_idx   <= '0;
            d_we    <= 1'b0;
            d_wdat  <= '0;
            d_oor   <= 1'b0;
            i_oor   <= 1'b0;
        end else begin
            d_state <= d_state_n;
            i_state <= i_state_n;
            d_cnt   <= d_cnt_n;
            i_cnt   <= i_cnt_n;
            if (d_state == S_IDLE && wb_cyc && wb_stb) begin
                d_idx  <= wb_adr[AW-1:0];
                d_we   <= wb_we;
                d_wdat <= wb_dat_i;
                d_oor  <= d_oor_in;
            end
            if (i_state == S_IDLE && wb_inst_cyc && wb_inst_stb) begin
                i_idx <= wb_inst_pc[AW-1:0];
                i_oor <= i_oor_in;
            end
        end
    end

    // Write commits on the ACK-entry edge; memory is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && d_enter && d_we_eff && !d_oor_eff)
            mem[d_idx_eff] <= d_wdat_eff;
    end

    // Registered acks and read data; data is zero outside the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_inst_ack <= 1'b0;
            wb_dat_o    <= '0;
            wb_inst_o   <= '0;
        end else begin
            wb_ack      <= d_enter;
            wb_inst_ack <= i_enter;
            wb_dat_o    <= (d_enter && !d_we_eff && !d_oor_eff) ? mem[d_idx_eff] : '0;
            wb_inst_o   <= (i_enter && !i_oor_eff) ? mem[i_idx_eff] : '0;
        end
    end

`ifdef WB_MEM_RANGE_ERR_EN
    // Sticky out-of-range flag, set on the ack edge of either port.
    always_ff @(posedge clk) begin
        if (rst)
            err_flag <= 1'b0;
        else if ((d_enter && d_oor_eff) || (i_enter && i_oor_eff))
            err_flag <= 1'b1;
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench for wb_mem_slave. A default-parameter
// instance covers the main scenarios; a WAIT_DATA=3 instance covers abort.
module tb_wb_mem_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [31:0] wb_adr = 0, wb_dat_i = 0, wb_dat_o;
    logic        wb_ack;
    logic        wb_inst_cyc = 0, wb_inst_stb = 0;
    logic [31:0] wb_inst_pc = 0, wb_inst_o;
    logic        wb_inst_ack, err_flag;

    logic        c3_cyc = 0, c3_stb = 0, c3_we = 0;
    logic [31:0] c3_adr = 0, c3_dat_i = 0, c3_dat_o;
    logic        c3_ack;
    logic        c3_icyc = 0, c3_istb = 0;
    logic [31:0] c3_ipc = 0, c3_io;
    logic        c3_iack, c3_err;

    typedef struct { logic [31:0] data; int lat; } exp_t;
    exp_t sb[$];
    exp_t isb[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_mem_slave dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .wb_inst_cyc(wb_inst_cyc), .wb_inst_stb(wb_inst_stb), .wb_inst_pc(wb_inst_pc),
        .wb_inst_o(wb_inst_o), .wb_inst_ack(wb_inst_ack), .err_flag(err_flag)
    );

    wb_mem_slave #(.WAIT_DATA(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .wb_cyc(c3_cyc), .wb_stb(c3_stb), .wb_we(c3_we), .wb_adr(c3_adr),
        .wb_dat_i(c3_dat_i), .wb_dat_o(c3_dat_o), .wb_ack(c3_ack),
        .wb_inst_cyc(c3_icyc), .wb_inst_stb(c3_istb), .wb_inst_pc(c3_ipc),
        .wb_inst_o(c3_io), .wb_inst_ack(c3_iack), .err_flag(c3_err)
    );

    // Data access on the default instance, called at a negedge with the port idle.
    // Expected ack cycle is 2; read data expected only in the ack cycle.
    task automatic data_access(input logic we, input logic [31:0] adr, dat, expd, input string nm);
        exp_t e;
        bit   got = 0;
        sb.push_back('{(we ? 32'h0 : expd), 2});
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (wb_ack) begin
                got = 1;
                e = sb.pop_front();
                wb_cyc = 0; wb_stb = 0;
                total_cnt++;
                if (k !== e.lat) $display("FAIL %s ack_cycle got %0d want %0d", nm, k, e.lat);
                else pass_cnt++;
                total_cnt++;
                if (wb_dat_o !== e.data) $display("FAIL %s dat_o got %h want %h", nm, wb_dat_o, e.data);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (wb_dat_o !== 32'h0) $display("FAIL %s dat_o_idle got %h want 0", nm, wb_dat_o);
                else pass_cnt++;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL %s ack_timeout got none want ack", nm);
            void'(sb.pop_front());
            wb_cyc = 0; wb_stb = 0;
        end
        @(negedge clk);
    endtask

    // Instruction fetch on the default instance; expected ack cycle is 1.
    task automatic inst_fetch(input logic [31:0] pc, expd, input string nm);
        exp_t e;
        bit   got = 0;
        isb.push_back('{expd, 1});
        wb_inst_cyc = 1; wb_inst_stb = 1; wb_inst_pc = pc;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (wb_inst_ack) begin
                got = 1;
                e = isb.pop_front();
                wb_inst_cyc = 0; wb_inst_stb = 0;
                total_cnt++;
                if (k !== e.lat) $display("FAIL %s ack_cycle got %0d want %0d", nm, k, e.lat);
                else pass_cnt++;
                total_cnt++;
                if (wb_inst_o !== e.data) $display("FAIL %s inst_o got %h want %h", nm, wb_inst_o, e.data);
                else pass_cnt++;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL %s ack_timeout got none want ack", nm);
            void'(isb.pop_front());
            wb_inst_cyc = 0; wb_inst_stb = 0;
        end
        @(negedge clk);
    endtask

    // Plain driver for the WAIT_DATA=3 instance; lat=0 means no ack seen.
    task automatic d3_access(input logic we, input logic [31:0] adr, dat,
                             output logic [31:0] rd, output int lat);
        lat = 0; rd = 'x;
        c3_cyc = 1; c3_stb = 1; c3_we = we; c3_adr = adr; c3_dat_i = dat;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (c3_ack) begin
                lat = k; rd = c3_dat_o;
                c3_cyc = 0; c3_stb = 0;
            end
        end
        c3_cyc = 0; c3_stb = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wb_ack, wb_inst_ack, err_flag, c3_ack, c3_iack, c3_err} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {wb_ack, wb_inst_ack, err_flag, c3_ack, c3_iack, c3_err});
        else pass_cnt++;
        total_cnt++;
        if ({wb_dat_o, wb_inst_o} !== 64'h0) $display("FAIL reset_data got %h want 0", {wb_dat_o, wb_inst_o});
        else pass_cnt++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        data_access(1, 32'd5, 32'hDEADBEEF, 0, "wr5");
        data_access(0, 32'd5, 0, 32'hDEADBEEF, "rd5");
    endtask

    task automatic test_inst_fetch();
        data_access(1, 32'd3, 32'h12345678, 0, "preload3");
        inst_fetch(32'd3, 32'h12345678, "fetch3");
    endtask

    // Two reads with cyc/stb held high; the second is accepted in the IDLE
    // cycle after ACK, so its ack follows three cycles after the first.
    task automatic test_back_to_back();
        int gap = 0;
        sb.push_back('{32'hDEADBEEF, 2});
        sb.push_back('{32'h12345678, 3});
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'd5;
        for (int n = 0; n < 2; n++) begin
            exp_t e;
            bit got = 0;
            for (int k = 1; k <= 20 && !got; k++) begin
                @(negedge clk);
                if (wb_ack) begin
                    got = 1; gap = k;
                    e = sb.pop_front();
                    total_cnt++;
                    if (gap !== e.lat) $display("FAIL b2b_lat%0d got %0d want %0d", n, gap, e.lat);
                    else pass_cnt++;
                    total_cnt++;
                    if (wb_dat_o !== e.data) $display("FAIL b2b_dat%0d got %h want %h", n, wb_dat_o, e.data);
                    else pass_cnt++;
                    wb_adr = 32'd3;
                    if (n == 1) begin wb_cyc = 0; wb_stb = 0; end
                end
            end
            if (!got) begin
                total_cnt++;
                $display("FAIL b2b_timeout%0d got none want ack", n);
                void'(sb.pop_front());
            end
        end
        wb_cyc = 0; wb_stb = 0;
        @(negedge clk);
    endtask

    // Write's ACK-entry edge coincides with the fetch's: fetch sees old word.
    task automatic test_same_word();
        data_access(1, 32'd7, 32'd1, 0, "preload7");
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'd7; wb_dat_i = 32'd2;
        @(negedge clk);
        wb_inst_cyc = 1; wb_inst_stb = 1; wb_inst_pc = 32'd7;
        @(negedge clk);
        total_cnt++;
        if ({wb_ack, wb_inst_ack} !== 2'b11) $display("FAIL same_edge_acks got %b want 11", {wb_ack, wb_inst_ack});
        else pass_cnt++;
        total_cnt++;
        if (wb_inst_o !== 32'd1) $display("FAIL same_edge_old got %h want 1", wb_inst_o);
        else pass_cnt++;
        wb_cyc = 0; wb_stb = 0; wb_inst_cyc = 0; wb_inst_stb = 0;
        @(negedge clk);
        inst_fetch(32'd7, 32'd2, "fetch7_new");
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int lat;
        bit seen = 0;
        d3_access(1, 32'd9, 32'h55, rd, lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL w3_lat got %0d want 4", lat);
        else pass_cnt++;
        c3_cyc = 1; c3_stb = 1; c3_we = 1; c3_adr = 32'd9; c3_dat_i = 32'hAA;
        @(negedge clk);
        @(negedge clk);
        c3_cyc = 0; c3_stb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (c3_ack) seen = 1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_ack got 1 want 0");
        else pass_cnt++;
        d3_access(0, 32'd9, 0, rd, lat);
        total_cnt++;
        if (rd !== 32'h55 || lat !== 4) $display("FAIL abort_mem got %h/%0d want 55/4", rd, lat);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_rd, exp_m0;
        logic        exp_err;
`ifdef WB_MEM_RANGE_ERR_EN
        exp_rd = 32'h0; exp_m0 = 32'h0BAD0000; exp_err = 1'b1;
`else
        exp_rd = 32'hCAFEF00D; exp_m0 = 32'hCAFEF00D; exp_err = 1'b0;
`endif
        data_access(1, 32'd0, 32'h0BAD0000, 0, "preload0");
        data_access(1, 32'h400, 32'hCAFEF00D, 0, "oor_wr");
        data_access(0, 32'h400, 0, exp_rd, "oor_rd");
        total_cnt++;
        if (err_flag !== exp_err) $display("FAIL err_flag got %b want %b", err_flag, exp_err);
        else pass_cnt++;
        data_access(0, 32'd0, 0, exp_m0, "rd0_after_oor");
        total_cnt++;
        if (err_flag !== exp_err) $display("FAIL err_flag_sticky got %b want %b", err_flag, exp_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        data_access(1, 32'd11, 32'h11, 0, "preload11");
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'd11; wb_dat_i = 32'h77;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        total_cnt++;
        if ({wb_ack, wb_inst_ack, err_flag} !== 3'b0 || {wb_dat_o, wb_inst_o} !== 64'h0)
            $display("FAIL rst_mid_outputs got %b/%h want 000/0", {wb_ack, wb_inst_ack, err_flag}, {wb_dat_o, wb_inst_o});
        else pass_cnt++;
        wb_cyc = 0; wb_stb = 0;
        rst = 0;
        @(negedge clk);
        total_cnt++;
        if (wb_ack !== 1'b0) $display("FAIL rst_mid_late_ack got 1 want 0");
        else pass_cnt++;
        data_access(0, 32'd11, 0, 32'h11, "rd11_after_rst");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_inst_fetch();
        test_back_to_back();
        test_same_word();
        test_abort();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
